// File: rtl/stat_pkg.sv
// Shared definitions for the cycle statistics counters: counter indices as
// decoded by the peripheral STATS_BASE window, counter count and default width.
package stat_pkg;

  localparam int N_CNT      = 6;
  localparam int DEF_CNT_W  = 32;

  localparam int CNT_TOTAL  = 0;
  localparam int CNT_RETIRE = 1;
  localparam int CNT_L1I    = 2;
  localparam int CNT_L1D    = 3;
  localparam int CNT_L2     = 4;
  localparam int CNT_PHASE  = 5;

endpackage

// File: rtl/stat_sat_counter.sv
// Single event counter with synchronous clear, sticky overflow flag and
// selectable saturate-or-wrap behaviour on overflow.
module stat_sat_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] value_r;
  logic             ovf_r;
  logic             at_max_s;

  assign at_max_s = (value_r == {CNT_W{1'b1}});

  // Counter and sticky overflow; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (clr) begin
      value_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (inc) begin
      if (at_max_s) begin
        ovf_r   <= 1'b1;
        value_r <= (SATURATE != 0) ? value_r : {CNT_W{1'b0}};
      end else begin
        ovf_r   <= ovf_r;
        value_r <= value_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      value_r <= value_r;
      ovf_r   <= ovf_r;
    end
  end

  assign value = value_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/cycle_stat_counters.sv
// Six performance counters with an atomically captured snapshot that the
// peripheral system reads word-by-word; snapshot holds steady between triggers.
module cycle_stat_counters
  import stat_pkg::*;
#(
  parameter int CNT_W              = DEF_CNT_W,
  parameter int SATURATE           = 1,
  parameter int AUTO_SNAP_ON_PHASE = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   run_i,
  input  logic                   clear_i,
  input  logic                   snap_i,
  input  logic                   phase_i,
  input  logic                   retire_i,
  input  logic                   l1i_stall_i,
  input  logic                   l1d_stall_i,
  input  logic                   l2_stall_i,
  output logic [N_CNT*CNT_W-1:0] cycle_counts_o,
  output logic [N_CNT-1:0]       overflow_o,
  output logic                   snap_valid_o
);

  logic                   phase_q_r;
  logic                   phase_edge_s;
  logic                   trigger_s;
  logic [N_CNT-1:0]       inc_s;
  logic [N_CNT*CNT_W-1:0] live_s;
  logic [N_CNT*CNT_W-1:0] snap_r;
  logic                   snap_valid_r;

  // Phase edge detect, snapshot trigger and per-counter increment enables
  always_comb begin
    phase_edge_s      = phase_i & ~phase_q_r;
    trigger_s         = snap_i | ((AUTO_SNAP_ON_PHASE != 0) & phase_edge_s & run_i);
    inc_s             = {N_CNT{1'b0}};
    inc_s[CNT_TOTAL]  = run_i;
    inc_s[CNT_RETIRE] = run_i & retire_i;
    inc_s[CNT_L1I]    = run_i & l1i_stall_i;
    inc_s[CNT_L1D]    = run_i & l1d_stall_i;
    inc_s[CNT_L2]     = run_i & l2_stall_i;
    inc_s[CNT_PHASE]  = run_i & phase_edge_s;
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    stat_sat_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clock_i),
      .rst   (reset_i),
      .inc   (inc_s[g]),
      .clr   (clear_i),
      .value (live_s[g*CNT_W +: CNT_W]),
      .ovf   (overflow_o[g])
    );
  end

  // Snapshot captures pre-increment, pre-clear live values on a trigger
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q_r    <= 1'b0;
      snap_r       <= {(N_CNT*CNT_W){1'b0}};
      snap_valid_r <= 1'b0;
    end else begin
      phase_q_r    <= phase_i;
      snap_valid_r <= trigger_s;
      if (trigger_s) begin
        snap_r <= live_s;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  assign cycle_counts_o = snap_r;
  assign snap_valid_o   = snap_valid_r;

endmodule

// File: tb/tb_cycle_stat_counters.sv
// Bench for cycle_stat_counters: three parameterisations driven in parallel and
// compared every cycle against an event-count reference model.
module tb_cycle_stat_counters;

  logic clk = 1'b0;
  logic rst, run, clr, snp, phase, ret, l1i, l1d, l2;

  logic [191:0] cc0;
  logic [47:0]  cc1, cc2;
  logic [5:0]   ov0, ov1, ov2;
  logic         sv0, sv1, sv2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cycle_stat_counters #(.CNT_W(32), .SATURATE(1), .AUTO_SNAP_ON_PHASE(1)) dut0 (
    .clock_i(clk), .reset_i(rst), .run_i(run), .clear_i(clr), .snap_i(snp),
    .phase_i(phase), .retire_i(ret), .l1i_stall_i(l1i), .l1d_stall_i(l1d),
    .l2_stall_i(l2), .cycle_counts_o(cc0), .overflow_o(ov0), .snap_valid_o(sv0));

  cycle_stat_counters #(.CNT_W(8), .SATURATE(1), .AUTO_SNAP_ON_PHASE(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .run_i(run), .clear_i(clr), .snap_i(snp),
    .phase_i(phase), .retire_i(ret), .l1i_stall_i(l1i), .l1d_stall_i(l1d),
    .l2_stall_i(l2), .cycle_counts_o(cc1), .overflow_o(ov1), .snap_valid_o(sv1));

  cycle_stat_counters #(.CNT_W(8), .SATURATE(0), .AUTO_SNAP_ON_PHASE(0)) dut2 (
    .clock_i(clk), .reset_i(rst), .run_i(run), .clear_i(clr), .snap_i(snp),
    .phase_i(phase), .retire_i(ret), .l1i_stall_i(l1i), .l1d_stall_i(l1d),
    .l2_stall_i(l2), .cycle_counts_o(cc2), .overflow_o(ov2), .snap_valid_o(sv2));

  // Reference model: event counts per instance
  int              mw[3]    = '{32, 8, 8};
  int              msat[3]  = '{1, 1, 0};
  int              mauto[3] = '{1, 1, 0};
  longint unsigned m_live[3][6];
  longint unsigned m_snap[3][6];
  bit              m_ovf[3][6];
  bit              m_sv[3];
  bit              m_phq;

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < 6; j++) begin
        m_live[m][j] = 0; m_snap[m][j] = 0; m_ovf[m][j] = 0;
      end
      m_sv[m] = 0;
    end
    m_phq = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    bit ev[6];
    bit trig;
    longint unsigned maxv;
    edge_seen = phase && !m_phq;
    ev = '{run, run && ret, run && l1i, run && l1d, run && l2, run && edge_seen};
    for (int m = 0; m < 3; m++) begin
      trig = snp || (mauto[m] != 0 && edge_seen && run);
      m_sv[m] = trig;
      if (trig) for (int j = 0; j < 6; j++) m_snap[m][j] = m_live[m][j];
      maxv = (64'd1 << mw[m]) - 64'd1;
      for (int j = 0; j < 6; j++) begin
        if (clr) begin
          m_live[m][j] = 0; m_ovf[m][j] = 0;
        end else if (ev[j]) begin
          if (m_live[m][j] == maxv) begin
            m_ovf[m][j] = 1;
            m_live[m][j] = (msat[m] != 0) ? maxv : 0;
          end else begin
            m_live[m][j] = m_live[m][j] + 1;
          end
        end
      end
    end
    m_phq = phase;
  endtask

  function automatic logic [191:0] exp_cc(int m);
    logic [191:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) r = r | (192'(m_snap[m][j]) << (mw[m] * j));
    return r;
  endfunction

  function automatic logic [5:0] exp_ov(int m);
    logic [5:0] r;
    for (int j = 0; j < 6; j++) r[j] = m_ovf[m][j];
    return r;
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cc0", cc0, exp_cc(0));
    chk("cc1", {144'd0, cc1}, exp_cc(1));
    chk("cc2", {144'd0, cc2}, exp_cc(2));
    chk("ov0", 192'(ov0), 192'(exp_ov(0)));
    chk("ov1", 192'(ov1), 192'(exp_ov(1)));
    chk("ov2", 192'(ov2), 192'(exp_ov(2)));
    chk("sv0", 192'(sv0), 192'(m_sv[0]));
    chk("sv1", 192'(sv1), 192'(m_sv[1]));
    chk("sv2", 192'(sv2), 192'(m_sv[2]));
  endtask

  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    run = 0; clr = 0; snp = 0; ret = 0; l1i = 0; l1d = 0; l2 = 0;
  endtask

  int pulses;

  initial begin
    rst = 1'b1; phase = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // 100 counting cycles, retire every other cycle, then snapshot
    for (int i = 0; i < 100; i++) begin
      run = 1; ret = (i % 2 == 0);
      tick();
    end
    idle_inputs(); snp = 1; tick(); snp = 0;
    chk("plan_total100", 192'(cc0[31:0]), 192'd100);
    chk("plan_retire50", 192'(cc0[63:32]), 192'd50);
    chk("plan_others0", 192'(cc0[191:64]), 192'd0);
    chk("plan_sv_hi", 192'(sv0), 192'd1);
    tick();
    chk("plan_sv_lo", 192'(sv0), 192'd0);

    // Stalls toggling with run low: nothing moves
    for (int i = 0; i < 20; i++) begin
      l1i = i[0]; l1d = ~i[0]; l2 = i[1]; ret = i[2];
      tick();
    end
    idle_inputs(); snp = 1; tick(); snp = 0;
    chk("hold_total", 192'(cc0[31:0]), 192'd100);
    chk("hold_l1i", 192'(cc0[95:64]), 192'd0);

    // Phase held high, low, high again: two auto snapshots
    pulses = 0;
    run = 1;
    phase = 1;
    for (int i = 0; i < 10; i++) begin tick(); pulses += int'(sv0); end
    phase = 0;
    for (int i = 0; i < 2; i++) begin tick(); pulses += int'(sv0); end
    phase = 1;
    tick(); pulses += int'(sv0);
    chk("phase_snap_pre", 192'(cc0[191:160]), 192'd1);
    phase = 0;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(sv0); end
    chk("phase_pulses", 192'(pulses), 192'd2);
    idle_inputs(); snp = 1; tick(); snp = 0;
    chk("phase_live2", 192'(cc0[191:160]), 192'd2);

    // Clear, count TOTAL to 500, then snapshot-and-clear together
    clr = 1; tick(); clr = 0;
    run = 1;
    for (int i = 0; i < 500; i++) tick();
    clr = 1; snp = 1; tick(); clr = 0; snp = 0;
    chk("sc_snap500", 192'(cc0[31:0]), 192'd500);
    chk("sc_ovf0", 192'(ov0), 192'd0);
    chk("sc_ovf_s", 192'(ov1), 192'd0);
    tick();
    run = 0; snp = 1; tick(); snp = 0;
    chk("sc_live1", 192'(cc0[31:0]), 192'd1);

    // Overflow on the narrow instances: 300 increments of TOTAL
    clr = 1; tick(); clr = 0;
    run = 1;
    for (int i = 0; i < 300; i++) tick();
    run = 0; snp = 1; tick(); snp = 0;
    chk("ovf_main300", 192'(cc0[31:0]), 192'd300);
    chk("ovf_sat_word", 192'(cc1[7:0]), 192'd255);
    chk("ovf_sat_flag", 192'(ov1[0]), 192'd1);
    chk("ovf_wrap_word", 192'(cc2[7:0]), 192'd44);
    chk("ovf_wrap_flag", 192'(ov2[0]), 192'd1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom % 4) != 0;
      ret = $urandom % 2; l1i = $urandom % 2; l1d = $urandom % 2; l2 = $urandom % 2;
      if ($urandom % 6 == 0) phase = ~phase;
      snp = ($urandom % 16) == 0;
      clr = ($urandom % 64) == 0;
      tick();
    end
    idle_inputs();

    // Asynchronous reset mid-cycle while counting
    run = 1; ret = 1;
    for (int i = 0; i < 5; i++) tick();
    snp = 1; tick(); snp = 0;
    #3 rst = 1;
    #1;
    chk("arst_cc0", cc0, 192'd0);
    chk("arst_ov0", 192'(ov0), 192'd0);
    chk("arst_sv0", 192'(sv0), 192'd0);
    chk("arst_cc2", 192'(cc2), 192'd0);
    model_reset();
    tick();
    #3 rst = 0;
    phase = 0;
    for (int i = 0; i < 37; i++) tick();
    idle_inputs(); snp = 1; tick(); snp = 0;
    chk("arst_restart", 192'(cc0[31:0]), 192'd37);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
